// File: rtl/pg_pkg.sv
// pg_pkg: state encodings, default timings and output decode for the power-gating sequencer.
package pg_pkg;
    typedef logic [3:0] pg_state_t;

    localparam pg_state_t S_ON      = 4'd0;
    localparam pg_state_t S_CLK_OFF = 4'd1;
    localparam pg_state_t S_ISO     = 4'd2;
    localparam pg_state_t S_SAVE    = 4'd3;
    localparam pg_state_t S_SW_OFF  = 4'd4;
    localparam pg_state_t S_OFF     = 4'd5;
    localparam pg_state_t S_SW_ON   = 4'd6;
    localparam pg_state_t S_RESTORE = 4'd7;
    localparam pg_state_t S_ISO_OFF = 4'd8;
    localparam pg_state_t S_CLK_ON  = 4'd9;

    localparam int ISO_SETUP_DEF      = 2;
    localparam int SAVE_CYCLES_DEF    = 3;
    localparam int RESTORE_CYCLES_DEF = 3;
    localparam int ACK_TIMEOUT_DEF    = 16;

    typedef struct packed {
        logic clk_en;
        logic iso_en;
        logic ret_save;
        logic ret_restore;
        logic pwr_sw_en_n;
    } pg_out_t;

    function automatic pg_out_t pg_decode(pg_state_t s);
        pg_out_t o;
        o.clk_en      = s == S_ON || s == S_CLK_ON;
        o.iso_en      = s inside {S_ISO, S_SAVE, S_SW_OFF, S_OFF, S_SW_ON, S_RESTORE};
        o.ret_save    = s == S_SAVE;
        o.ret_restore = s == S_RESTORE;
        o.pwr_sw_en_n = s == S_SW_OFF || s == S_OFF;
        return o;
    endfunction
endpackage

// File: rtl/pg_timer.sv
// pg_timer: loadable down-counter that saturates at zero; done is high while the count is zero.
module pg_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= load ? value : (cnt != '0 ? cnt - 1'b1 : cnt);
    end

    assign done = cnt == '0;
endmodule

// File: rtl/pg_sequencer.sv
// pg_sequencer: orders clock gate, isolation, retention and header switch for a power-gated domain.
module pg_sequencer
    import pg_pkg::*;
#(
    parameter int ISO_SETUP      = ISO_SETUP_DEF,
    parameter int SAVE_CYCLES    = SAVE_CYCLES_DEF,
    parameter int RESTORE_CYCLES = RESTORE_CYCLES_DEF,
    parameter int ACK_TIMEOUT    = ACK_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sleep_req,
    input  logic pwr_ack,
    output logic clk_en,
    output logic iso_en,
    output logic ret_save,
    output logic ret_restore,
    output logic pwr_sw_en_n,
    output logic domain_on,
    output logic busy,
    output logic err
);
    localparam int M1   = ISO_SETUP > SAVE_CYCLES ? ISO_SETUP : SAVE_CYCLES;
    localparam int M2   = RESTORE_CYCLES > ACK_TIMEOUT ? RESTORE_CYCLES : ACK_TIMEOUT;
    localparam int MAXP = M1 > M2 ? M1 : M2;
    localparam int W    = $clog2(MAXP) + 1;

    pg_state_t    state, nxt;
    logic         load, done, ack_late;
    logic [W-1:0] load_val;

    always_comb begin
        nxt = state;
        case (state)
            S_ON:      nxt = sleep_req ? S_CLK_OFF : S_ON;
            S_CLK_OFF: nxt = S_ISO;
            S_ISO:     nxt = done ? S_SAVE : S_ISO;
            S_SAVE:    nxt = done ? S_SW_OFF : S_SAVE;
            S_SW_OFF:  nxt = pwr_ack ? S_SW_OFF : S_OFF;
            S_OFF:     nxt = sleep_req ? S_OFF : S_SW_ON;
            S_SW_ON:   nxt = pwr_ack ? S_RESTORE : S_SW_ON;
            S_RESTORE: nxt = done ? S_ISO_OFF : S_RESTORE;
            S_ISO_OFF: nxt = S_CLK_ON;
            S_CLK_ON:  nxt = S_ON;
            default:   nxt = S_ON;
        endcase
    end

    // Timer is loaded with duration-1 on entry so done marks the last cycle of the state.
    assign load     = nxt != state;
    assign load_val = nxt == S_ISO     ? W'(ISO_SETUP - 1) :
                      nxt == S_SAVE    ? W'(SAVE_CYCLES - 1) :
                      nxt == S_RESTORE ? W'(RESTORE_CYCLES - 1) :
                      (nxt == S_SW_OFF || nxt == S_SW_ON) ? W'(ACK_TIMEOUT - 1) : '0;
    assign ack_late = done && ((state == S_SW_OFF && pwr_ack) || (state == S_SW_ON && !pwr_ack));

    pg_timer #(.W(W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .value (load_val),
        .done  (done)
    );

    // Outputs are registered from the next state so they switch glitch-free with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                                             <= S_ON;
            {clk_en, iso_en, ret_save, ret_restore, pwr_sw_en_n} <= pg_decode(S_ON);
            domain_on                                         <= 1'b1;
            busy                                              <= 1'b0;
            err                                               <= 1'b0;
        end else begin
            state                                             <= nxt;
            {clk_en, iso_en, ret_save, ret_restore, pwr_sw_en_n} <= pg_decode(nxt);
            domain_on                                         <= nxt == S_ON;
            busy                                              <= nxt != S_ON && nxt != S_OFF;
            err                                               <= err | ack_late;
        end
    end
endmodule
